// File: rtl/rv32_irq_trap_ctrl.sv
// rv32_irq_trap_ctrl
//   Machine-mode trap CSR file with NUM_IRQ synchronised external interrupt
//   lines (each level- or rising-edge-sensitive) plus the machine timer
//   interrupt. It arbitrates with fixed priority and dispatches traps to a
//   direct or vectored handler.
//
// Ports
//   clk, reset_n   core clock, asynchronous active-low reset
//   csr_addr       CSR address of the MEM-stage access
//   csr_wdata      operand (rs1 or zero-extended uimm)
//   csr_op         funct3: x01 write, x10 set, x11 clear
//   csr_wen        CSR access strobe
//   csr_rdata      old value of the addressed CSR (combinational)
//   timer_int      machine timer interrupt, level, already synchronous
//   irq_i          external interrupt lines, asynchronous
//   current_pc     PC of the instruction in MEM
//   pipe_ready     low while the pipeline is stalled (blocks trap entry)
//   mret_exec      MRET commits in MEM this cycle
//   trap_taken     one-cycle redirect pulse
//   trap_pc        handler target, valid while trap_taken is high
//   mret_pc        return target (mepc)
module rv32_irq_trap_ctrl #(
  parameter int                 NUM_IRQ       = 4,
  parameter int                 SYNC_STAGES   = 2,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE_MASK = '0,
  parameter int                 VECTORED_EN   = 1,
  parameter logic [31:0]        MTVEC_RESET   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  input  logic [2:0]         csr_op,
  input  logic               csr_wen,
  output logic [31:0]        csr_rdata,
  input  logic               timer_int,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [31:0]        current_pc,
  input  logic               pipe_ready,
  input  logic               mret_exec,
  output logic               trap_taken,
  output logic [31:0]        trap_pc,
  output logic [31:0]        mret_pc
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  // Without vectored support the mode field is hardwired to direct.
  localparam logic [31:0] MTVEC_MASK = (VECTORED_EN != 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;

  typedef enum logic {S_IDLE, S_TAKE} state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0]              w_irq_lvl;
  logic [NUM_IRQ-1:0]              r_irq_dly;
  logic [NUM_IRQ-1:0]              w_irq_rise;
  logic [NUM_IRQ-1:0]              r_irq_pend;
  logic [NUM_IRQ-1:0]              w_pend_clr;
  logic [NUM_IRQ-1:0]              w_irq_ip;

  logic                            r_mstatus_mie;
  logic                            r_mstatus_mpie;
  logic                            r_mie_mtie;
  logic [NUM_IRQ-1:0]              r_mie_irq;
  logic [31:0]                     r_mtvec;
  logic [31:0]                     r_mscratch;
  logic [29:0]                     r_mepc;
  logic [31:0]                     r_mcause;
  logic [4:0]                      r_take_cause;

  logic [31:0]                     w_mstatus;
  logic [31:0]                     w_mie;
  logic [31:0]                     w_mip;
  logic [31:0]                     w_csr_new;
  logic                            w_csr_write;
  logic [4:0]                      w_cause;
  logic                            w_pe_any;
  logic                            w_trap_req;
  logic [31:0]                     w_base;
  logic                            w_unused_bits;

  assign w_unused_bits = ^{csr_op[2], current_pc[1:0]};

  // Synchroniser chain plus one extra flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_irq_dly <= '0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], irq_i};
      r_irq_dly <= w_irq_lvl;
    end
  end

  assign w_irq_lvl  = r_sync[SYNC_STAGES-1];
  assign w_irq_rise = w_irq_lvl & ~r_irq_dly;

  // Edge-line pending latches; a new edge beats a same-cycle software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_pend <= '0;
    end else begin
      r_irq_pend <= ((r_irq_pend & ~w_pend_clr) | w_irq_rise) & IRQ_EDGE_MASK;
    end
  end

  // Architectural views of the packed CSRs.
  always_comb begin
    w_mstatus        = '0;
    w_mstatus[3]     = r_mstatus_mie;
    w_mstatus[7]     = r_mstatus_mpie;
    w_mstatus[12:11] = 2'b11;
    w_mie            = '0;
    w_mie[7]         = r_mie_mtie;
    w_mip            = '0;
    w_mip[7]         = timer_int;
    w_irq_ip         = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      w_irq_ip[k]    = IRQ_EDGE_MASK[k] ? r_irq_pend[k] : w_irq_lvl[k];
      w_mie[16+k]    = r_mie_irq[k];
      w_mip[16+k]    = w_irq_ip[k];
    end
  end

  // Read mux: unimplemented addresses read zero.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS:  csr_rdata = w_mstatus;
      ADDR_MIE:      csr_rdata = w_mie;
      ADDR_MTVEC:    csr_rdata = r_mtvec;
      ADDR_MSCRATCH: csr_rdata = r_mscratch;
      ADDR_MEPC:     csr_rdata = {r_mepc, 2'b00};
      ADDR_MCAUSE:   csr_rdata = r_mcause;
      ADDR_MIP:      csr_rdata = w_mip;
      default:       csr_rdata = '0;
    endcase
  end

  // Read-modify-write result; a trap entry discards the access because the
  // instruction is replayed after mret.
  always_comb begin
    case (csr_op[1:0])
      2'b01:   w_csr_new = csr_wdata;
      2'b10:   w_csr_new = csr_rdata | csr_wdata;
      2'b11:   w_csr_new = csr_rdata & ~csr_wdata;
      default: w_csr_new = csr_rdata;
    endcase
    w_csr_write = csr_wen && (csr_op[1:0] != 2'b00) && !w_trap_req;
    w_pend_clr  = '0;
    if (w_csr_write && (csr_addr == ADDR_MIP)) begin
      for (int k = 0; k < NUM_IRQ; k++) begin
        w_pend_clr[k] = IRQ_EDGE_MASK[k] & ~w_csr_new[16+k];
      end
    end
  end

  // Fixed priority: timer first, then line 0 upward. Scanning from the
  // highest line down lets the lower-numbered sources overwrite the choice.
  always_comb begin
    w_cause  = '0;
    w_pe_any = 1'b0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (w_irq_ip[k] && r_mie_irq[k]) begin
        w_cause  = 5'(16 + k);
        w_pe_any = 1'b1;
      end
    end
    if (timer_int && r_mie_mtie) begin
      w_cause  = 5'd7;
      w_pe_any = 1'b1;
    end
  end

  assign w_trap_req = (r_state == S_IDLE) && r_mstatus_mie && w_pe_any &&
                      pipe_ready && !mret_exec;

  // Trap FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Trap FSM next state: TAKE lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_trap_req) w_state_nxt = S_TAKE;
      S_TAKE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Trap FSM outputs; mtvec modes 10/11 fall back to direct dispatch.
  always_comb begin
    trap_taken = (r_state == S_TAKE);
    w_base     = {r_mtvec[31:2], 2'b00};
    trap_pc    = w_base;
    if (r_mtvec[1:0] == 2'b01) begin
      trap_pc = w_base + {25'd0, r_take_cause, 2'b00};
    end
  end

  assign mret_pc = {r_mepc, 2'b00};

  // CSR state. Trap entry excludes CSR writes; mret is applied after the
  // CSR write so it overrides MIE/MPIE from a same-cycle mstatus write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mie_irq      <= '0;
      r_mtvec        <= MTVEC_RESET & MTVEC_MASK;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_take_cause   <= '0;
    end else if (w_trap_req) begin
      r_mepc         <= current_pc[31:2];
      r_mcause       <= {1'b1, 26'd0, w_cause};
      r_take_cause   <= w_cause;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else begin
      if (w_csr_write) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            r_mstatus_mie  <= w_csr_new[3];
            r_mstatus_mpie <= w_csr_new[7];
          end
          ADDR_MIE: begin
            r_mie_mtie <= w_csr_new[7];
            r_mie_irq  <= w_csr_new[16 +: NUM_IRQ];
          end
          ADDR_MTVEC:    r_mtvec    <= w_csr_new & MTVEC_MASK;
          ADDR_MSCRATCH: r_mscratch <= w_csr_new;
          ADDR_MEPC:     r_mepc     <= w_csr_new[31:2];
          ADDR_MCAUSE:   r_mcause   <= w_csr_new;
          default: ;
        endcase
      end
      if (mret_exec) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rv32_irq_trap_ctrl.md
Name: rv32_irq_trap_ctrl

Overview:
- Parametrised successor to the core's single-source CSR/trap file.
- Implements machine-mode trap CSRs plus N synchronised external interrupt lines, each level- or edge-sensitive, alongside the timer interrupt.
- Provides fixed-priority arbitration and direct or vectored trap dispatch.
- Sits beside the pipeline: CSR access from the MEM stage, trap/mret redirect to the PC logic.

Parameters:
NUM_IRQ, 4, number of external interrupt lines irq_i (legal 1..16)
SYNC_STAGES, 2, flop stages on each irq_i line (legal 2..3)
IRQ_EDGE_MASK, 0, per-line mode: bit k = 1 makes irq_i[k] rising-edge latched, 0 makes it level
VECTORED_EN, 1, 1 allows mtvec mode 01 (vectored); 0 hardwires mtvec[1:0] = 00
MTVEC_RESET, 32'h0000_0000, reset value of mtvec

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
csr_addr  input  12  CSR address
csr_wdata  input  32  operand (rs1 value or zero-extended uimm, already selected)
csr_op  input  3  funct3: x01 write, x10 set, x11 clear
csr_wen  input  1  CSR access strobe
csr_rdata  output  32  old value of addressed CSR, combinational
timer_int  input  1  machine timer interrupt, level, already synchronous
irq_i  input  NUM_IRQ  external interrupt lines, asynchronous
current_pc  input  32  PC of the instruction in MEM stage
pipe_ready  input  1  0 while the pipeline is stalled; no trap entry then
mret_exec  input  1  MRET committing in MEM this cycle
trap_taken  output  1  one-cycle redirect pulse
trap_pc  output  32  handler target, valid while trap_taken = 1
mret_pc  output  32  equals mepc, combinational

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] read 11; other bits read 0.
  - mie 0x304: bit7 MTIE, bits 16+k IE for each line.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: bit7 MTIP = timer_int; bit 16+k = synchronised level (level line) or latched pending (edge line).
- Unimplemented addresses read 0; writes to them are ignored.
- CSR write result: write = wdata; set = old | wdata; clear = old & ~wdata. Applied on the rising edge with csr_wen = 1. Writes to read-only bits are ignored.
- mip writability: only edge-line pending bits are writable, and only clear takes effect (write 0 / clear op). A set of an edge pending bit is ignored.
- Synchroniser: irq_i passes SYNC_STAGES flops; the edge detector uses one further flop. A rising edge sets the pending bit. A set in the same cycle as a CSR clear wins.
- Pending-enabled: pe = mip & mie. Request = mstatus.MIE & (pe != 0) & pipe_ready & !mret_exec.
- Priority: MTI highest, then irq 0, irq 1, … irq NUM_IRQ-1. Cause code is 7 for the timer, 16+k for line k.
- FSM states:
  - IDLE -> TAKE when request = 1.
  - TAKE -> IDLE unconditionally after 1 cycle.
  - On the IDLE->TAKE edge: mepc <= current_pc; mcause <= {1'b1, cause}; MPIE <= MIE; MIE <= 0. A csr_wen in that cycle is discarded entirely, because the instruction is replayed after mret.
- In TAKE: trap_taken = 1 (registered). trap_pc = base, or base + 4*cause when mtvec[1:0] = 01; base = {mtvec[31:2], 2'b00}. mtvec mode values 10/11 behave as direct.
- trap_taken is asserted exactly 1 cycle after the request cycle. MIE = 0 prevents re-entry.
- MRET (mret_exec = 1): MIE <= MPIE; MPIE <= 1. Takes priority over a same-cycle interrupt request, which is re-evaluated the next cycle.
- Simultaneous mret_exec and a csr_wen to mstatus: the mret update wins for MIE/MPIE.
- Reset values:
  - All CSRs 0 except mtvec = MTVEC_RESET and MPP = 11.
  - Synchroniser, edge and pending flops 0; FSM IDLE; trap_taken 0.
  - An in-progress TAKE is abandoned on reset.

Test Plan:
- CSR ops: write mscratch 0xA5A5_0000, set 0x0000_00FF, clear 0x0000_000F -> csr_rdata reads 0xA5A5_00F0.
- Direct timer trap: mtvec = 0x100, mie.MTIE = 1, MIE = 1, timer_int = 1 at current_pc 0x40 -> trap_taken 1 cycle after the request; trap_pc = 0x100; mepc = 0x40; mcause = 0x8000_0007; MIE = 0; MPIE = 1.
- Vectored priority: mtvec = 0x201, irq_i[2] and irq_i[0] asserted together, both enabled, timer off -> cause 16, trap_pc = 0x240. Drop irq_i[0] and mret -> next trap cause 18, trap_pc = 0x248.
- Edge line (IRQ_EDGE_MASK = 1): 1-cycle pulse on irq_i[0] with MIE = 0 -> mip bit16 latches and stays set. Enable MIE -> trap taken. CSR clear of mip bit16 -> bit reads 0 with no re-trap.
- Stall / simultaneity: pending interrupt with pipe_ready = 0 for 5 cycles -> no trap_taken. Request together with mret_exec -> mret applied first, trap 1 cycle later. Request together with a csr_wen to mscratch -> the write is discarded.
- Reset mid-TAKE: assert reset_n = 0 during TAKE -> trap_taken = 0 immediately; all CSRs return to reset values.
